// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch unit.
// Issues one sequential fetch at a time to a simple request/ack memory port
// and buffers the returned {pc, instruction} pairs in a small circular queue
// that feeds decode. A redirect (jump) flushes the queue, retargets the fetch
// PC and, if a fetch is still in flight, swallows its late acknowledge.
module if_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  input  logic              mem_busy_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_data_i,
  output logic              inst_valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
);

  // DEPTH must be a power of two so the pointers wrap by simple overflow.
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // IDLE: may issue a fetch; WAIT: fetch outstanding, its ack is wanted;
  // FLUSH: fetch outstanding but it belongs to a discarded path.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] jump_target;

  // Redirect targets are word aligned; the two low bits are dropped.
  assign jump_target = {jump_pc_i[ADDR_W-1:2], 2'b00};

  logic unused_jump_lsbs;
  assign unused_jump_lsbs = ^jump_pc_i[1:0];

  // Per-cycle queue/memory events; a jump overrides every one of them.
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (rst) begin
      issue = 1'b0;
      push  = 1'b0;
      pop   = 1'b0;
    end else begin
      // A new request is only possible from IDLE, which also guarantees it
      // never coincides with an ack and is spaced at least two cycles apart.
      issue = (state_q == ST_IDLE) && !mem_busy_i && !jump_i && (count_q < FULL_CNT);
      push  = (state_q == ST_WAIT) && mem_ack_i && !jump_i;
      pop   = (count_q != {CNT_W{1'b0}}) && !stall_i && !jump_i;
    end
  end

  // Next pointer and occupancy values for the non-jump case.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // Push and pop together leave occupancy unchanged.
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Fetch FSM, fetch PC and queue bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else if (jump_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= jump_target;
      // If a fetch is still in flight its ack must be swallowed later;
      // an ack arriving in this very cycle closes it out immediately.
      case (state_q)
        ST_WAIT:  state_q <= mem_ack_i ? ST_IDLE : ST_FLUSH;
        ST_FLUSH: state_q <= mem_ack_i ? ST_IDLE : ST_FLUSH;
        default:  state_q <= ST_IDLE;
      endcase
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            state_q    <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_FLUSH: begin
          // Stale ack: drop the data and leave fetch_pc on the new path.
          if (mem_ack_i) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Queue storage; contents of empty slots are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= mem_data_i;
    end
  end

  // fetch_pc only changes on ack or jump, so while a request is outstanding
  // it is exactly the issued address.
  assign mem_req_o    = issue;
  assign mem_addr_o   = rst ? '0 : fetch_pc_q;
  assign inst_valid_o = !rst && (count_q != {CNT_W{1'b0}});
  assign inst_o       = rst ? 32'h0 : inst_mem_q[rd_ptr_q];
  assign inst_pc_o    = rst ? '0 : pc_mem_q[rd_ptr_q];

endmodule
